// File: rtl/sram_block_reader_pkg.sv
// Shared constants for the SRAM block reader: FSM encoding and the bus widths
// used by the SRAM arbiter test-runner port.
package sram_block_reader_pkg;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_DATA_WIDTH = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;
endpackage

// File: rtl/sram_block_reader_sync_fifo.sv
// Small synchronous FIFO with flush; head word is presented combinationally.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      push_data,
    output logic [DATA_WIDTH-1:0]      head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush wins over a simultaneous push/pop: the caller discards that word.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end
endmodule

// File: rtl/sram_block_reader.sv
// Avalon-MM read master that fetches a block of consecutive SRAM words and
// streams them out through a small FIFO.
module sram_block_reader
    import sram_block_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         base_address,
    input  logic [CNT_WIDTH-1:0]          word_count,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         mm_address,
    output logic [BE_WIDTH-1:0]           mm_byteenable,
    output logic                          mm_read,
    output logic                          mm_write,
    input  logic [DATA_WIDTH-1:0]         mm_readdata,
    input  logic                          mm_waitrequest,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    state
);
    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic                  done_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  xfer;
    logic                  stalled;

    // Output stream: a word moves on every cycle with out_valid && out_ready;
    // out_data is held stable while out_valid is high and out_ready is low.
    assign state         = state_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign mm_address    = addr_q;
    assign mm_byteenable = '1;
    assign mm_write      = 1'b0;
    assign out_valid     = !fifo_empty;

    // ABORT is only entered with a stalled read, so the request stays up there.
    assign mm_read = ((state_q == ST_READ) && !fifo_full) || (state_q == ST_ABORT);
    assign xfer    = mm_read && !mm_waitrequest;
    assign stalled = mm_read && mm_waitrequest;
    assign push    = (state_q == ST_READ) && xfer && !abort;
    assign pop     = out_valid && out_ready;
    assign flush   = (abort && ((state_q == ST_IDLE) || ((state_q == ST_READ) && !stalled)))
                   || ((state_q == ST_ABORT) && !mm_waitrequest);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!abort && start) begin
                        addr_q      <= base_address;
                        remaining_q <= word_count;
                        if (word_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        state_q <= stalled ? ST_ABORT : ST_IDLE;
                    end else if (xfer) begin
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        remaining_q <= remaining_q - CNT_WIDTH'(1);
                        if (remaining_q == CNT_WIDTH'(1)) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_ABORT: begin
                    if (!mm_waitrequest) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (mm_readdata),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );
endmodule

// File: tb/tb_sram_block_reader.sv
// Directed bench for sram_block_reader: SRAM model on the bus side and a
// scoreboard queue checked by a monitor on the output stream.
module tb_sram_block_reader;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [19:0] base_address;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [19:0] mm_address;
    logic [1:0]  mm_byteenable;
    logic        mm_read;
    logic        mm_write;
    logic [15:0] mm_readdata;
    logic        mm_waitrequest;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_level;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit busy_seen = 0;
    logic [15:0] exp_q[$];
    logic [19:0] bus_q[$];

    always #5 clock = ~clock;

    sram_block_reader dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_address   (base_address),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mm_address     (mm_address),
        .mm_byteenable  (mm_byteenable),
        .mm_read        (mm_read),
        .mm_write       (mm_write),
        .mm_readdata    (mm_readdata),
        .mm_waitrequest (mm_waitrequest),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .state          (state)
    );

    function automatic logic [15:0] mem_word(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'hC3A};
    endfunction

    assign mm_readdata = mem_word(mm_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_block(input logic [19:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [19:0] a;
            a = base + 20'(i);
            exp_q.push_back(mem_word(a));
        end
    endtask

    task automatic do_start(input logic [19:0] base, input logic [15:0] cnt);
        start        = 1'b1;
        base_address = base;
        word_count   = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((busy || out_valid || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_timeout", (n < 300) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    task automatic check_reset_values();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mm_read", mm_read, 0);
        check("rst_mm_address", mm_address, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_level", fifo_level, 0);
    endtask

    // Monitor: records bus transfers, done pulses and checks every popped word.
    always @(negedge clock) begin
        if (reset_n) begin
            if (mm_read && !mm_waitrequest) bus_q.push_back(mm_address);
            if (busy) busy_seen = 1;
            if (done) begin
                done_cnt++;
                check("done_with_busy_low", busy, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    check("stream_word", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int d0;
        reset_n        = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        base_address   = '0;
        word_count     = '0;
        mm_waitrequest = 1'b0;
        out_ready      = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check_reset_values();
        check("mm_write_low", mm_write, 0);
        check("byteenable_ones", mm_byteenable, 2'b11);

        // Basic block
        out_ready = 1'b1;
        bus_q.delete();
        push_block(20'h00010, 3);
        do_start(20'h00010, 16'd3);
        check("basic_busy", busy, 1);
        check("basic_first_addr", mm_address, 20'h00010);
        wait_drain();
        check("basic_nreads", bus_q.size(), 3);
        if (bus_q.size() == 3) begin
            check("basic_addr0", bus_q[0], 20'h00010);
            check("basic_addr2", bus_q[2], 20'h00012);
        end
        check("basic_done_cnt", done_cnt, 1);

        // Stall on the second read
        bus_q.delete();
        push_block(20'h00010, 3);
        do_start(20'h00010, 16'd3);
        tick();
        mm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_read_held", mm_read, 1);
            check("stall_addr_held", mm_address, 20'h00011);
            tick();
        end
        mm_waitrequest = 1'b0;
        wait_drain();
        check("stall_nreads", bus_q.size(), 3);
        check("stall_done_cnt", done_cnt, 2);

        // Backpressure
        out_ready = 1'b0;
        bus_q.delete();
        push_block(20'h00100, 10);
        do_start(20'h00100, 16'd10);
        repeat (8) tick();
        check("bp_nreads", bus_q.size(), 4);
        check("bp_read_low", mm_read, 0);
        check("bp_level", fifo_level, 4);
        out_ready = 1'b1;
        wait_drain();
        check("bp_total_reads", bus_q.size(), 10);
        if (bus_q.size() == 10) check("bp_last_addr", bus_q[9], 20'h00109);

        // Address wrap
        bus_q.delete();
        push_block(20'hFFFFE, 4);
        do_start(20'hFFFFE, 16'd4);
        wait_drain();
        check("wrap_nreads", bus_q.size(), 4);
        if (bus_q.size() == 4) begin
            check("wrap_addr1", bus_q[1], 20'hFFFFF);
            check("wrap_addr2", bus_q[2], 20'h00000);
            check("wrap_addr3", bus_q[3], 20'h00001);
        end

        // Zero count
        bus_q.delete();
        busy_seen = 0;
        d0 = done_cnt;
        do_start(20'h00050, 16'd0);
        check("zero_done_pulse", done, 1);
        check("zero_read_low", mm_read, 0);
        repeat (3) tick();
        check("zero_done_cnt", done_cnt, d0 + 1);
        check("zero_no_reads", bus_q.size(), 0);
        check("zero_busy_never", busy_seen, 0);

        // Abort during a stalled read
        out_ready = 1'b0;
        d0 = done_cnt;
        do_start(20'h00200, 16'd6);
        tick();
        tick();
        mm_waitrequest = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_held", busy, 1);
        check("abort_read_held", mm_read, 1);
        check("abort_addr_held", mm_address, 20'h00202);
        tick();
        tick();
        check("abort_read_still", mm_read, 1);
        mm_waitrequest = 1'b0;
        tick();
        check("abort_flushed", fifo_level, 0);
        check("abort_no_valid", out_valid, 0);
        check("abort_busy_low", busy, 0);
        check("abort_read_low", mm_read, 0);
        repeat (2) tick();
        check("abort_no_done", done_cnt, d0);
        out_ready = 1'b1;
        bus_q.delete();
        push_block(20'h00020, 2);
        do_start(20'h00020, 16'd2);
        wait_drain();
        check("post_abort_nreads", bus_q.size(), 2);

        // Reset in the middle of a block; start while busy is ignored
        out_ready = 1'b0;
        do_start(20'h00300, 16'd8);
        tick();
        tick();
        do_start(20'h00400, 16'd1);
        check("busy_start_ignored", mm_address, 20'h00303);
        reset_n = 1'b0;
        tick();
        check_reset_values();
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        bus_q.delete();
        push_block(20'h00040, 2);
        do_start(20'h00040, 16'd2);
        wait_drain();
        check("post_reset_nreads", bus_q.size(), 2);
        if (bus_q.size() == 2) check("post_reset_addr0", bus_q[0], 20'h00040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_block_reader.md
Name: sram_block_reader

Overview:
- Avalon-MM read master for the test-runner port of the SRAM arbiter (drives tr_address/tr_read/tr_byteenable, consumes tr_readdata/tr_waitrequest).
- Fetches a block of consecutive SRAM words from a programmed base address.
- Buffers the words in a small FIFO and presents them to the test runner as a valid/ready stream.
- Read-only master: the write request is tied inactive.

Parameters:
- ADDR_WIDTH, 20, word address width (matches SRAM arbiter)
- DATA_WIDTH, 16, data word width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- CNT_WIDTH, 16, width of the word-count field
- FIFO_DEPTH, 4, output FIFO depth in words (power of two, >= 2)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- abort  in  1  cancel current block and flush FIFO
- base_address  in  ADDR_WIDTH  first word address, latched on accepted start
- word_count  in  CNT_WIDTH  number of words to read, latched on accepted start
- busy  out  1  high from accepted start until last word captured or abort completes
- done  out  1  one-cycle pulse when the last word of a block is captured
- mm_address  out  ADDR_WIDTH  to tr_address
- mm_byteenable  out  BE_WIDTH  to tr_byteenable, all ones
- mm_read  out  1  to tr_read
- mm_write  out  1  to tr_write, constant 0
- mm_readdata  in  DATA_WIDTH  from tr_readdata
- mm_waitrequest  in  1  from tr_waitrequest
- out_data  out  DATA_WIDTH  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset_n low at a clock edge):
  - State IDLE; FIFO empty.
  - busy=0, done=0, mm_read=0, mm_address=0, out_valid=0, fifo_level=0.
  - out_data is don't-care while out_valid=0.
- States: IDLE, READ, ABORT.
- IDLE:
  - start=1 latches base_address into the address register and word_count into the remaining counter.
  - If word_count=0: stay in IDLE and pulse done on the next cycle; no bus cycles, busy stays 0.
  - Otherwise: go to READ and set busy=1 from the next cycle.
- READ:
  - mm_read = !fifo_full, combinational from registered state/level.
  - A transfer completes on a cycle with mm_read && !mm_waitrequest.
  - Read latency is zero: mm_readdata is captured into the FIFO in the completing cycle.
  - Because the FIFO only fills by capture, mm_read and mm_address stay stable for the whole waitrequest stall (Avalon rule).
  - On completion: address increments by 1 (wraps modulo 2^ADDR_WIDTH) and the remaining counter decrements.
  - When the final word completes: go to IDLE, pulse done the next cycle, deassert busy the next cycle.
  - start is ignored in READ.
- FIFO:
  - Push = transfer completion; pop = out_valid && out_ready.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - Full is evaluated on the registered level: a pop in the same cycle does not enable a read while full.
  - No overflow is possible. Pop on empty is impossible because out_valid=0.
  - Words remaining in the FIFO after done stay available until popped.
- abort:
  - In IDLE: flushes the FIFO next cycle.
  - In READ with no stalled transfer (mm_read=0, or waitrequest=0 this cycle): go to IDLE, flush the FIFO, no done, busy=0 next cycle; data captured that cycle is discarded.
  - In READ with a stalled transfer (mm_read=1 && waitrequest=1): go to ABORT. mm_read and mm_address are held until waitrequest drops, the completing word is discarded, then go to IDLE with the FIFO flushed.
  - busy stays 1 in ABORT.
- Simultaneous start and abort in IDLE: abort wins, start ignored.
- Reset mid-operation: immediate return to reset values; an in-flight read is dropped (arbiter is stateless).
- Widths: the remaining counter is CNT_WIDTH; the maximum block is 2^CNT_WIDTH-1 words.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, READ=2'd1, ABORT=2'd2)
  - default ADDR_WIDTH/DATA_WIDTH shared with sram_arb
- One sub-module: sync_fifo.
  - Parameterised DATA_WIDTH/DEPTH.
  - push/pop/flush inputs; full/empty/level outputs; head data.
  - Synchronous active-low reset.

Test Plan:
- Basic block: SRAM model, waitrequest=0, out_ready=1; start with base=0x00010, count=3 → reads at 0x00010..0x00012 on consecutive cycles; stream words equal memory contents in order; done one pulse; busy falls with done.
- Stall: waitrequest high for 5 cycles on the second read → mm_address=0x00011 and mm_read held for all 5 cycles; exactly 3 words delivered, no duplicates.
- Backpressure: count=10, out_ready=0 → exactly 4 reads issued, then mm_read=0 with fifo_level=4. Raise out_ready → remaining 6 words follow; total 10 in order.
- Wrap and zero count: base=0xFFFFE, count=4 → addresses FFFFE, FFFFF, 00000, 00001. Then count=0 → done pulse, no mm_read, busy never high.
- Abort during stall: abort while read is stalled → mm_read held until waitrequest low, that word discarded, FIFO flushed, done never pulses, busy=0 after completion; new start works normally.
- Reset mid-block: reset_n low for 1 cycle during READ → all outputs at reset values next cycle; start ignored while busy before reset, accepted after.
